// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the line-buffer SRAM arbiter and its clients.
// Holds the state encoding and the default geometry.
package sram_arbiter_pkg;

    localparam int unsigned AwDefault      = 10;
    localparam int unsigned DwDefault      = 8;
    localparam int unsigned MaxWaitDefault = 4;

    // Encoding chosen so the state register bits are the SRAM pins: {CE, WE}.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b11,
        ST_WR   = 2'b00,
        ST_RD   = 2'b01
    } state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes plus SRAM pins of the line-buffer arbiter.
// The arbiter uses the slave view; the requesters and the SRAM use the master view.
interface sram_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic          CE;
    logic          WE;
    logic [DW-1:0] Q;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, Q,
        output wr_gnt, rd_gnt, rd_data, rd_vld, A, D, CE, WE
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, Q,
        input  wr_gnt, rd_gnt, rd_data, rd_vld, A, D, CE, WE
    );
endinterface

// File: rtl/sram_arbiter_wait_cnt.sv
// Saturating starvation counter: counts cycles a read request is refused.
// sat_o tells the arbiter to push the read ahead of a competing write.
module arb_wait_cnt #(
    parameter int unsigned MaxWait = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic sat_o
);
    localparam logic [3:0] SatVal = 4'(MaxWait);

    logic [3:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != SatVal)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == SatVal);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one write stream and one read stream onto a single-port line-buffer SRAM.
// Writes win by default; a read refused MAX_WAIT times in a row is forced ahead.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned AW       = AwDefault,
    parameter int unsigned DW       = DwDefault,
    parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
    input logic           clk,
    input logic           RST,
    sram_arbiter_if.slave bus
);
    state_e        state_q;
    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic [1:0]    vld_q;
    logic          wr_gnt, rd_gnt, starved;

    arb_wait_cnt #(
        .MaxWait (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i (clk),
        .rst_i (RST),
        .clr_i (~bus.rd_req | rd_gnt),
        .inc_i (bus.rd_req & ~rd_gnt),
        .sat_o (starved)
    );

    always_comb begin
        rd_gnt = ~RST & bus.rd_req & (~bus.wr_req | starved);
        wr_gnt = ~RST & bus.wr_req & ~rd_gnt;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            vld_q   <= '0;
        end else begin
            vld_q <= {vld_q[0], rd_gnt};
            if (wr_gnt) begin
                state_q <= ST_WR;
                a_q     <= bus.wr_addr;
                d_q     <= bus.wr_data;
            end else if (rd_gnt) begin
                state_q <= ST_RD;
                a_q     <= bus.rd_addr;
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign bus.wr_gnt  = wr_gnt;
    assign bus.rd_gnt  = rd_gnt;
    assign bus.A       = a_q;
    assign bus.D       = d_q;
    assign bus.CE      = state_q[1];
    assign bus.WE      = state_q[0];
    assign bus.rd_vld  = vld_q[1];
    assign bus.rd_data = bus.Q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and constrained-random bench for sram_arbiter with a registered-read SRAM model.
module tb_sram_arbiter;
    localparam int unsigned AW       = 10;
    localparam int unsigned DW       = 8;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [DW-1:0] mem   [1<<AW];
    logic [DW-1:0] ref_m [1<<AW];
    logic [DW-1:0] sram_q = '0;

    sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.Q = sram_q;

    always @(posedge clk) begin
        if (!bus.CE) begin
            if (!bus.WE) mem[bus.A] <= bus.D;
            else         sram_q     <= mem[bus.A];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mems();
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]   = 8'(i) ^ 8'hC3;
            ref_m[i] = 8'(i) ^ 8'hC3;
        end
    endtask

    initial begin
        logic [7:0]    exp_wr, exp_rd;
        logic          pw, pr, rv_old;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pdata, pexp, rdat_old;
        int            rd_wait;

        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        bus.wr_addr = 10'h3AA;
        bus.wr_data = 8'h55;
        bus.rd_addr = 10'h155;
        init_mems();
        mem[10'h080] = 8'h3C;

        // Reset: grants suppressed, registers at reset values
        @(negedge clk);
        check_eq("rst_wr_gnt", bus.wr_gnt, 0);
        check_eq("rst_rd_gnt", bus.rd_gnt, 0);
        next_cycle();
        next_cycle();
        check_eq("rst_pins", {bus.CE, bus.WE, bus.A, bus.D}, {2'b11, 10'h000, 8'h00});
        check_eq("rst_rd_vld", bus.rd_vld, 0);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        RST        = 1'b0;
        next_cycle();

        // Write only
        bus.wr_req  = 1'b1;
        bus.wr_addr = 10'h005;
        bus.wr_data = 8'hA7;
        @(negedge clk);
        check_eq("wr_gnt", bus.wr_gnt, 1);
        check_eq("wr_rd_gnt", bus.rd_gnt, 0);
        next_cycle();
        bus.wr_req = 1'b0;
        check_eq("wr_cmd", {bus.CE, bus.WE, bus.A, bus.D}, {2'b00, 10'h005, 8'hA7});
        next_cycle();
        check_eq("wr_idle", {bus.CE, bus.WE, bus.A, bus.D}, {2'b11, 10'h005, 8'hA7});
        check_eq("wr_mem", mem[10'h005], 8'hA7);

        // Read only
        bus.rd_req  = 1'b1;
        bus.rd_addr = 10'h080;
        @(negedge clk);
        check_eq("rd_gnt", bus.rd_gnt, 1);
        next_cycle();
        bus.rd_req = 1'b0;
        check_eq("rd_cmd", {bus.CE, bus.WE, bus.A, bus.D}, {2'b01, 10'h080, 8'hA7});
        check_eq("rd_vld_t1", bus.rd_vld, 0);
        next_cycle();
        check_eq("rd_vld_t2", bus.rd_vld, 1);
        check_eq("rd_data_t2", bus.rd_data, 8'h3C);
        check_eq("rd_idle_t2", {bus.CE, bus.WE}, 2'b11);
        next_cycle();
        check_eq("rd_vld_t3", bus.rd_vld, 0);

        // Contention: writes 0-3, forced read 4, writes 5-7
        exp_wr      = 8'b1110_1111;
        exp_rd      = 8'b0001_0000;
        bus.wr_req  = 1'b1;
        bus.rd_req  = 1'b1;
        bus.wr_addr = 10'h010;
        bus.wr_data = 8'h11;
        bus.rd_addr = 10'h020;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("cont_wr_gnt_%0d", c), bus.wr_gnt, exp_wr[c]);
            check_eq($sformatf("cont_rd_gnt_%0d", c), bus.rd_gnt, exp_rd[c]);
            next_cycle();
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        next_cycle();
        next_cycle();

        // Streaming 128 back-to-back writes
        for (int i = 0; i < 128; i++) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = 10'h380 + 10'(i);
            bus.wr_data = 8'(i) ^ 8'h5A;
            @(negedge clk);
            check_eq("stream_gnt", bus.wr_gnt, 1);
            next_cycle();
            check_eq($sformatf("stream_cmd_%0d", i), {bus.CE, bus.WE, bus.A, bus.D},
                     {2'b00, 10'h380 + 10'(i), 8'(i) ^ 8'h5A});
        end
        bus.wr_req = 1'b0;
        next_cycle();
        check_eq("stream_end", {bus.CE, bus.WE}, 2'b11);

        // Reset mid-read drops the read
        bus.rd_req  = 1'b1;
        bus.rd_addr = 10'h0F0;
        @(negedge clk);
        check_eq("rstrd_gnt", bus.rd_gnt, 1);
        next_cycle();
        bus.rd_req = 1'b0;
        RST        = 1'b1;
        next_cycle();
        RST = 1'b0;
        check_eq("rstrd_pins", {bus.CE, bus.WE, bus.A}, {2'b11, 10'h000});
        check_eq("rstrd_vld_a", bus.rd_vld, 0);
        next_cycle();
        check_eq("rstrd_vld_b", bus.rd_vld, 0);
        next_cycle();

        // Random traffic against a reference memory
        init_mems();
        pw       = 1'b0;
        pr       = 1'b0;
        rv_old   = 1'b0;
        paddr    = '0;
        pdata    = '0;
        pexp     = '0;
        rdat_old = '0;
        rd_wait  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (pw) begin
                check_eq("rnd_wr_cmd", {bus.CE, bus.WE, bus.A, bus.D}, {2'b00, paddr, pdata});
            end else if (pr) begin
                check_eq("rnd_rd_cmd", {bus.CE, bus.WE, bus.A}, {2'b01, paddr});
            end else begin
                check_eq("rnd_idle", {bus.CE, bus.WE}, 2'b11);
            end
            check_eq("rnd_rd_vld", bus.rd_vld, rv_old);
            if (rv_old) check_eq("rnd_rd_data", bus.rd_data, rdat_old);
            rv_old   = pr;
            rdat_old = pexp;

            if (!bus.wr_req || pw) begin
                bus.wr_req  = ($urandom_range(0, 3) != 0);
                bus.wr_addr = 10'($urandom_range(0, 15));
                bus.wr_data = 8'($urandom);
            end
            if (!bus.rd_req || pr) begin
                bus.rd_req  = ($urandom_range(0, 1) != 0);
                bus.rd_addr = 10'($urandom_range(0, 15));
            end

            @(negedge clk);
            check_eq("rnd_excl", bus.wr_gnt & bus.rd_gnt, 0);
            pw = bus.wr_req & bus.wr_gnt;
            pr = bus.rd_req & bus.rd_gnt;
            if (pw) begin
                paddr               = bus.wr_addr;
                pdata               = bus.wr_data;
                ref_m[bus.wr_addr]  = bus.wr_data;
            end else if (pr) begin
                paddr = bus.rd_addr;
                pexp  = ref_m[bus.rd_addr];
            end
            if (bus.rd_req) begin
                if (bus.rd_gnt) begin
                    check_eq("rnd_rd_wait", rd_wait <= int'(MAX_WAIT), 1);
                    rd_wait = 0;
                end else begin
                    rd_wait++;
                end
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
